// File: rtl/onedconv_tile_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onedconv_pkg                                                          |
// | Shared types and layer geometry table for the 1D conv tile sequencer |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package onedconv_pkg;

  localparam int TBL_DEPTH = 9;
  localparam int TBL_LEN_W = 10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_CFG = 3'd1,
    S_WAIT_W   = 3'd2,
    S_START    = 3'd3,
    S_RUN      = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  typedef struct packed {
    logic [7:0]           in_ch;
    logic [7:0]           out_ch;
    logic [3:0]           k;
    logic [1:0]           stride;
    logic [TBL_LEN_W-1:0] in_len;
  } layer_t;

  // Every row has in_len >= k and at least one channel on each side.
  localparam layer_t LAYER_TBL [TBL_DEPTH] = '{
    '{8'd1,  8'd16, 4'd7, 2'd1, 10'd256},
    '{8'd16, 8'd32, 4'd5, 2'd2, 10'd250},
    '{8'd32, 8'd32, 4'd3, 2'd1, 10'd123},
    '{8'd32, 8'd64, 4'd3, 2'd2, 10'd121},
    '{8'd64, 8'd64, 4'd5, 2'd1, 10'd60},
    '{8'd64, 8'd48, 4'd3, 2'd1, 10'd56},
    '{8'd48, 8'd32, 4'd3, 2'd2, 10'd54},
    '{8'd32, 8'd64, 4'd1, 2'd1, 10'd40},
    '{8'd64, 8'd1,  4'd3, 2'd1, 10'd32}
  };

endpackage
`default_nettype wire

// File: rtl/onedconv_layer_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onedconv_layer_rom                                                    |
// | Combinational layer lookup with output length and group counts       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module onedconv_layer_rom
  import onedconv_pkg::*;
#(
  parameter int NUM_LAYERS = 9,
  parameter int OC_PAR     = 16,
  parameter int IC_PAR     = 8,
  parameter int LEN_W      = 10
) (
  input  logic [3:0]       i_layer_id,
  output logic [3:0]       o_k,
  output logic [1:0]       o_stride,
  output logic [LEN_W-1:0] o_in_len,
  output logic [LEN_W-1:0] o_out_len,
  output logic [7:0]       o_og,
  output logic [7:0]       o_ig
);

  layer_t           w_row;
  logic [LEN_W-1:0] w_diff;

  always_comb begin
    w_row = LAYER_TBL[0];
    if (int'(i_layer_id) < NUM_LAYERS && int'(i_layer_id) < TBL_DEPTH)
      w_row = LAYER_TBL[i_layer_id];
    o_k       = w_row.k;
    o_stride  = w_row.stride;
    o_in_len  = LEN_W'(w_row.in_len);
    w_diff    = o_in_len - LEN_W'(w_row.k);
    // Stride is only ever 1 or 2, so the divide is a conditional shift.
    o_out_len = ((w_row.stride == 2'd2) ? (w_diff >> 1) : w_diff) + LEN_W'(1);
    o_og      = 8'((int'(w_row.out_ch) + OC_PAR - 1) / OC_PAR);
    o_ig      = 8'((int'(w_row.in_ch) + IC_PAR - 1) / IC_PAR);
  end

endmodule
`default_nettype wire

// File: rtl/onedconv_tile_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onedconv_tile_sequencer                                               |
// | Walks oc/ic tile groups of one conv layer with weight handshakes     |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module onedconv_tile_sequencer
  import onedconv_pkg::*;
#(
  parameter int NUM_LAYERS = 9,
  parameter int OC_PAR     = 16,
  parameter int IC_PAR     = 8,
  parameter int LEN_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       layer_id,
  input  logic             weight_ready,
  input  logic             tile_done,
  input  logic             abort,
  output logic             weight_req,
  output logic             tile_start,
  output logic             acc_en,
  output logic [7:0]       oc_base,
  output logic [7:0]       ic_base,
  output logic [3:0]       cfg_k,
  output logic [1:0]       cfg_stride,
  output logic [LEN_W-1:0] cfg_in_len,
  output logic [LEN_W-1:0] cfg_out_len,
  output logic             busy,
  output logic             layer_complete,
  output logic             cfg_err
);

  state_t           r_state;
  logic [3:0]       r_layer;
  logic [7:0]       r_oc_grp;
  logic [7:0]       r_ic_grp;
  logic [7:0]       r_og;
  logic [7:0]       r_ig;

  logic [3:0]       w_k;
  logic [1:0]       w_stride;
  logic [LEN_W-1:0] w_in_len;
  logic [LEN_W-1:0] w_out_len;
  logic [7:0]       w_og;
  logic [7:0]       w_ig;
  logic             w_last_ic;
  logic             w_last_oc;

  onedconv_layer_rom #(
    .NUM_LAYERS (NUM_LAYERS),
    .OC_PAR     (OC_PAR),
    .IC_PAR     (IC_PAR),
    .LEN_W      (LEN_W)
  ) u_rom (
    .i_layer_id (r_layer),
    .o_k        (w_k),
    .o_stride   (w_stride),
    .o_in_len   (w_in_len),
    .o_out_len  (w_out_len),
    .o_og       (w_og),
    .o_ig       (w_ig)
  );

  assign w_last_ic = (r_ic_grp == r_ig - 8'd1);
  assign w_last_oc = (r_oc_grp == r_og - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_layer        <= '0;
      r_oc_grp       <= '0;
      r_ic_grp       <= '0;
      r_og           <= '0;
      r_ig           <= '0;
      weight_req     <= 1'b0;
      tile_start     <= 1'b0;
      acc_en         <= 1'b0;
      oc_base        <= '0;
      ic_base        <= '0;
      cfg_k          <= '0;
      cfg_stride     <= '0;
      cfg_in_len     <= '0;
      cfg_out_len    <= '0;
      busy           <= 1'b0;
      layer_complete <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      weight_req     <= 1'b0;
      tile_start     <= 1'b0;
      layer_complete <= 1'b0;
      cfg_err        <= 1'b0;
      // Abort outranks everything, including a tile_done in the same cycle.
      if (abort && r_state != S_IDLE) begin
        r_state  <= S_IDLE;
        busy     <= 1'b0;
        r_oc_grp <= '0;
        r_ic_grp <= '0;
        oc_base  <= '0;
        ic_base  <= '0;
        acc_en   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (int'(layer_id) < NUM_LAYERS) begin
                r_layer <= layer_id;
                r_state <= S_LOAD_CFG;
                busy    <= 1'b1;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          S_LOAD_CFG: begin
            cfg_k       <= w_k;
            cfg_stride  <= w_stride;
            cfg_in_len  <= w_in_len;
            cfg_out_len <= w_out_len;
            r_og        <= w_og;
            r_ig        <= w_ig;
            r_oc_grp    <= '0;
            r_ic_grp    <= '0;
            oc_base     <= '0;
            ic_base     <= '0;
            acc_en      <= 1'b0;
            weight_req  <= 1'b1;
            r_state     <= S_WAIT_W;
          end
          S_WAIT_W: begin
            if (weight_ready) begin
              tile_start <= 1'b1;
              r_state    <= S_START;
            end
          end
          S_START: r_state <= S_RUN;
          S_RUN: begin
            if (tile_done) r_state <= S_NEXT;
          end
          S_NEXT: begin
            if (w_last_ic && w_last_oc) begin
              layer_complete <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              if (w_last_ic) begin
                r_ic_grp <= '0;
                r_oc_grp <= r_oc_grp + 8'd1;
                ic_base  <= '0;
                oc_base  <= oc_base + 8'(OC_PAR);
                acc_en   <= 1'b0;
              end else begin
                r_ic_grp <= r_ic_grp + 8'd1;
                ic_base  <= ic_base + 8'(IC_PAR);
                acc_en   <= 1'b1;
              end
              weight_req <= 1'b1;
              r_state    <= S_WAIT_W;
            end
          end
          S_DONE: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
